// File: rtl/uart_tx_frm.sv
// FIFO-buffered UART frame transmitter.
// Run-time period, parity and stop count are latched per frame.
module uart_tx_frm #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int TW        = 20
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          fire_tx,
    input  logic [DW-1:0] data_tx,
    input  logic [TW-1:0] tbit_period,
    input  logic [1:0]    par_mode,
    input  logic          stop2,
    output logic          tx,
    output logic          done_tx,
    output logic          busy,
    output logic          full,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DW);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] cnt;
    logic [TW-1:0] per_q;
    logic [IW-1:0] bit_idx;
    logic [DW-1:0] sh;
    logic [DW-1:0] head;
    logic [1:0]    par_q;
    logic          stop2_q;
    logic          par_bit;
    logic          pop;
    logic          push;
    logic          finish_bit;
    logic          par_en;

    assign head       = mem[rd_ptr];
    assign pop        = (state == IDLE || state == DONE) && count != '0;
    assign full       = count == CW'(DEPTH);
    assign push       = fire_tx && (!full || pop);
    assign finish_bit = cnt == per_q - TW'(1);
    assign par_en     = par_q == 2'd1 || par_q == 2'd2;
    assign busy       = state != IDLE || count != '0;
    assign done_tx    = state == DONE;

    always_comb begin
        tx = 1'b1;
        unique case (state)
            START:   tx = 1'b0;
            DATA:    tx = (MSB_FIRST != 0) ? sh[DW-1] : sh[0];
            PARITY:  tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

    // Storage only; emptiness is tracked by the reset pointers and count.
    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= data_tx;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            per_q   <= TW'(1);
            par_q   <= 2'd0;
            stop2_q <= 1'b0;
            par_bit <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            ovf <= fire_tx && !push;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (state != IDLE && state != DONE)
                cnt <= finish_bit ? '0 : cnt + TW'(1);

            unique case (state)
                IDLE, DONE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        state   <= START;
                        sh      <= head;
                        per_q   <= (tbit_period == '0) ? TW'(1)
                                                       : tbit_period;
                        par_q   <= par_mode;
                        stop2_q <= stop2;
                        par_bit <= (^head) ^ (par_mode == 2'd2);
                    end else begin
                        state <= IDLE;
                    end
                end
                START:
                    if (finish_bit)
                        state <= DATA;
                DATA:
                    if (finish_bit) begin
                        if (bit_idx == IW'(DW - 1)) begin
                            bit_idx <= '0;
                            state   <= par_en ? PARITY : STOP1;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            if (MSB_FIRST != 0)
                                sh <= {sh[DW-2:0], 1'b0};
                            else
                                sh <= {1'b0, sh[DW-1:1]};
                        end
                    end
                PARITY:
                    if (finish_bit)
                        state <= STOP1;
                STOP1:
                    if (finish_bit)
                        state <= stop2_q ? STOP2 : DONE;
                STOP2:
                    if (finish_bit)
                        state <= DONE;
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Directed bench for uart_tx_frm: frame table plus
// back-to-back, config-latch and reset sequences.
module tb_uart_tx_frm;

    logic        clk_sys;
    logic        rst_n;
    logic        fire_tx;
    logic [7:0]  data_tx;
    logic [19:0] tbit_period;
    logic [1:0]  par_mode;
    logic        stop2;
    logic        tx_m, done_m, busy_m, full_m, ovf_m;
    logic        tx_l, done_l, busy_l, full_l, ovf_l;

    uart_tx_frm #(.DW(8), .DEPTH(4), .MSB_FIRST(1), .TW(20)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .fire_tx(fire_tx),
        .data_tx(data_tx), .tbit_period(tbit_period),
        .par_mode(par_mode), .stop2(stop2), .tx(tx_m),
        .done_tx(done_m), .busy(busy_m), .full(full_m), .ovf(ovf_m)
    );

    uart_tx_frm #(.DW(8), .DEPTH(4), .MSB_FIRST(0), .TW(20)) dut_l (
        .clk_sys(clk_sys), .rst_n(rst_n), .fire_tx(fire_tx),
        .data_tx(data_tx), .tbit_period(tbit_period),
        .par_mode(par_mode), .stop2(stop2), .tx(tx_l),
        .done_tx(done_l), .busy(busy_l), .full(full_l), .ovf(ovf_l)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  d;
        logic [19:0] per;
        int          peff;
        logic [1:0]  pm;
        logic        s2;
        logic        lsb;
        logic [15:0] fr;
        int          nb;
        int          dc;
    } vec_t;

    vec_t        vecs[6];
    int          checks;
    int          errors;
    int          ndone, novf, nearly, bad, k, pos, idx;
    logic [7:0]  rx[6];
    logic [7:0]  wa[6];
    logic [15:0] fr;
    logic [10:0] f2;
    logic        txv;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // frame bits listed first-sent on the left
        vecs[0] = '{8'hA5, 20'd4, 4, 2'd0, 1'b0, 1'b0,
                    16'b0101001011, 10, 41};
        vecs[1] = '{8'h03, 20'd2, 2, 2'd2, 1'b1, 1'b1,
                    16'b011000000111, 12, 25};
        vecs[2] = '{8'h5A, 20'd0, 1, 2'd0, 1'b0, 1'b0,
                    16'b0010110101, 10, 11};
        vecs[3] = '{8'h07, 20'd3, 3, 2'd1, 1'b0, 1'b0,
                    16'b00000011111, 11, 34};
        vecs[4] = '{8'hFF, 20'd1, 1, 2'd3, 1'b1, 1'b1,
                    16'b01111111111, 11, 12};
        vecs[5] = '{8'h03, 20'd2, 2, 2'd1, 1'b0, 1'b0,
                    16'b00000001101, 11, 23};
        wa = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};

        rst_n = 1'b0;
        fire_tx = 1'b0;
        data_tx = '0;
        tbit_period = 20'd1;
        par_mode = 2'd0;
        stop2 = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("reset tx", tx_m, 1);
        chk("reset tx_l", tx_l, 1);
        chk("reset done", done_m | done_l, 0);
        chk("reset busy", busy_m | busy_l, 0);
        chk("reset full", full_m | full_l, 0);
        chk("reset ovf", ovf_m | ovf_l, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(negedge clk_sys);
            tbit_period = vecs[v].per;
            par_mode = vecs[v].pm;
            stop2 = vecs[v].s2;
            data_tx = vecs[v].d;
            fire_tx = 1'b1;
            @(posedge clk_sys);
            #1 fire_tx = 1'b0;
            fr = vecs[v].fr;
            for (int c = 0; c <= vecs[v].dc + 1; c++) begin
                @(negedge clk_sys);
                txv = vecs[v].lsb ? tx_l : tx_m;
                if (c == 0) begin
                    chk($sformatf("v%0d busy c0", v), busy_m, 1);
                    chk($sformatf("v%0d idle tx", v), txv, 1);
                end else if (c < vecs[v].dc) begin
                    idx = (c - 1) / vecs[v].peff;
                    chk($sformatf("v%0d tx c%0d", v, c), txv,
                        fr[vecs[v].nb - 1 - idx]);
                    if (c == vecs[v].dc - 1)
                        chk($sformatf("v%0d early done", v), done_m, 0);
                end else if (c == vecs[v].dc) begin
                    chk($sformatf("v%0d done", v), done_m, 1);
                    chk($sformatf("v%0d done tx", v), txv, 1);
                end else begin
                    chk($sformatf("v%0d busy end", v), busy_m, 0);
                    chk($sformatf("v%0d done end", v), done_m, 0);
                end
            end
        end

        // back-to-back frames, overflow, push on full with pop
        @(negedge clk_sys);
        tbit_period = 20'd1;
        par_mode = 2'd0;
        stop2 = 1'b0;
        fire_tx = 1'b1;
        data_tx = 8'h11;
        ndone = 0;
        novf = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk_sys);
            if (done_m) ndone++;
            if (ovf_m) novf++;
            if (c >= 1 && c <= 66) begin
                k = (c - 1) / 11;
                pos = (c - 1) % 11;
                if (pos == 0)
                    chk($sformatf("b2b start f%0d", k), tx_m, 0);
                if (pos >= 1 && pos <= 8)
                    rx[k] = {rx[k][6:0], tx_m};
                if (pos == 10) begin
                    chk($sformatf("b2b done f%0d", k), done_m, 1);
                    chk($sformatf("b2b gap tx f%0d", k), tx_m, 1);
                    chk($sformatf("b2b byte f%0d", k), rx[k], wa[k]);
                end
            end
            if (c == 3) chk("b2b full c3", full_m, 0);
            if (c == 4) chk("b2b full c4", full_m, 1);
            if (c == 4) chk("b2b ovf c4", ovf_m, 0);
            if (c == 5) chk("b2b ovf c5", ovf_m, 1);
            if (c == 12) chk("b2b ovf c12", ovf_m, 0);
            if (c == 12) chk("b2b full c12", full_m, 1);
            if (c == 23) chk("b2b full c23", full_m, 0);
            if (c == 67) chk("b2b busy c67", busy_m, 0);
            fire_tx = (c + 1 <= 5) || (c + 1 == 12);
            data_tx = (c + 1 == 12) ? 8'h77 : 8'(8'h11 * (c + 2));
        end
        fire_tx = 1'b0;
        chk("b2b frame count", ndone, 6);
        chk("b2b ovf count", novf, 1);

        // config change mid-frame only affects the next frame
        f2 = 11'b0_10000001_0_1;
        @(negedge clk_sys);
        tbit_period = 20'd4;
        par_mode = 2'd0;
        stop2 = 1'b0;
        data_tx = 8'hC3;
        fire_tx = 1'b1;
        nearly = 0;
        for (int c = 0; c <= 132; c++) begin
            @(negedge clk_sys);
            if (c < 41 && done_m) nearly++;
            if (c == 39) chk("cfg stop tx", tx_m, 1);
            if (c == 41) begin
                chk("cfg done1", done_m, 1);
                chk("cfg early done", nearly, 0);
            end
            if (c >= 42 && c < 130 && (c - 42) % 8 == 4) begin
                idx = (c - 42) / 8;
                chk($sformatf("cfg f2 bit%0d", idx), tx_m, f2[10 - idx]);
            end
            if (c == 129) chk("cfg done2 early", done_m, 0);
            if (c == 130) chk("cfg done2", done_m, 1);
            if (c == 131) chk("cfg busy end", busy_m, 0);
            fire_tx = (c + 1 == 10);
            if (c + 1 == 10) begin
                data_tx = 8'h81;
                tbit_period = 20'd8;
                par_mode = 2'd1;
            end
        end
        fire_tx = 1'b0;

        // asynchronous reset during DATA with words queued
        @(negedge clk_sys);
        tbit_period = 20'd4;
        par_mode = 2'd0;
        stop2 = 1'b0;
        data_tx = 8'h0F;
        fire_tx = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk_sys);
            if (c == 6) begin
                chk("rst pre tx", tx_m, 0);
                chk("rst pre busy", busy_m, 1);
            end
            fire_tx = (c + 1 <= 2);
            data_tx = (c + 1 == 1) ? 8'hF0 : 8'hAA;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst tx", tx_m, 1);
        chk("rst tx_l", tx_l, 1);
        chk("rst busy", busy_m | busy_l, 0);
        chk("rst done", done_m | done_l, 0);
        chk("rst full", full_m | full_l, 0);
        chk("rst ovf", ovf_m | ovf_l, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk_sys);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        chk("rst stays idle", bad, 0);

        // a fresh push still works after reset
        @(negedge clk_sys);
        tbit_period = 20'd1;
        data_tx = 8'h80;
        fire_tx = 1'b1;
        @(posedge clk_sys);
        #1 fire_tx = 1'b0;
        repeat (12) @(negedge clk_sys);
        chk("post rst done", done_m, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frm.md
# uart_tx_frm

Parametrised, FIFO-buffered serial byte transmitter for the commu_top link; successor to the fixed 8-bit, MSB-first, no-parity, two-stop transmitter. Software-side logic pushes words with a one-cycle `fire_tx` strobe into an internal FIFO. The block serialises each word on `tx` with run-time selectable bit period, parity and stop-bit count, and streams frames back-to-back with no CPU gap.

## Interface
- `DW`, default 8: data bits per frame, legal 5..9.
- `DEPTH`, default 4: FIFO entries, power of two, 2..16.
- `MSB_FIRST`, default 1: 1 sends data[DW-1] first; 0 sends data[0] first.
- `TW`, default 20: width of the bit-period input.

- `clk_sys`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fire_tx`  in  1  one-cycle push strobe.
- `data_tx`  in  DW  word pushed when `fire_tx`=1.
- `tbit_period`  in  TW  clocks per bit; 0 is treated as 1.
- `par_mode`  in  2  0 none, 1 even, 2 odd, 3 none.
- `stop2`  in  1  1 gives two stop bits, 0 gives one.
- `tx`  out  1  serial line, idle high.
- `done_tx`  out  1  one-cycle pulse at the end of each frame.
- `busy`  out  1  high when state is not IDLE or FIFO is not empty.
- `full`  out  1  FIFO holds DEPTH entries.
- `ovf`  out  1  one-cycle pulse when a push is dropped.

## Operation
- **FIFO:** DEPTH x DW, with a count register of log2(DEPTH)+1 bits.
  - Push when `fire_tx` and (not `full` or a pop occurs on the same edge).
  - Otherwise the word is discarded and `ovf` pulses on the next cycle.
- **Frame start:** leaving IDLE or DONE with the FIFO non-empty, one edge performs all of:
  - pops the FIFO head into shift register `sh`;
  - latches `tbit_period` (0 becomes 1), `par_mode` and `stop2` into frame-config registers;
  - computes `par_bit` = XOR of the word (even) or its inverse (odd).
  - Input changes mid-frame have no effect.
- **States:** IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE -> START when FIFO not empty.
  - START -> DATA on `finish_bit`.
  - DATA -> DATA while `bit_idx` < DW-1, incrementing `bit_idx` and shifting `sh` on each `finish_bit`.
  - DATA -> PARITY if parity is enabled, else -> STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if `stop2`, else -> DONE.
  - STOP2 -> DONE.
  - DONE -> START (with pop) if FIFO not empty, else -> IDLE.
- **Bit counter:** `cnt` (TW bits) increments in START through STOP2.
  - `finish_bit` = (`cnt` == period-1), after which `cnt` clears.
  - `cnt` is forced to 0 in IDLE and DONE.
- **`tx` decode** (registered state and `sh` only; no input-to-output path):
  - START: 0.
  - DATA: `sh[DW-1]` (MSB_FIRST=1) or `sh[0]`; `sh` shifts toward the sent end.
  - PARITY: `par_bit`.
  - All other states: 1.
- **Outputs:** `done_tx` = (state==DONE); `busy` and `full` are decoded from registers.
- **Reset** (any time, including mid-frame):
  - state IDLE, `cnt` 0, `bit_idx` 0, `sh` 0, FIFO emptied;
  - `tx`=1, `done_tx`=0, `busy`=0, `full`=0, `ovf`=0;
  - a partial frame is abandoned with the line immediately high.

## Timing
- **Push:** a push at edge E is visible to the FSM from edge E+1; the START state begins at edge E+1 (first `tx`=0 cycle follows E+1).
- **Frame length:** P x (1 + DW + p + s) cycles, followed by 1 DONE cycle.
  - P = latched period; p = 1 if parity is enabled, else 0; s = 1 or 2 stop bits.
- **Back-to-back frames:** the inter-frame gap is exactly one DONE cycle with `tx`=1, in addition to the stop bits.
- **Push on full:** a push on a full FIFO with a pop on the same edge (DONE/IDLE exit) is accepted; count is unchanged.
- **Period 1:** P=1 gives one cycle per bit; `finish_bit` is asserted every cycle.
- **Minimum gap:** `done_tx` pulses are at least P x (2+DW) + 1 cycles apart.

## Test plan
- **Single frame:** DW=8, MSB_FIRST=1, P=4, par 0, stop2=0, push 0xA5 at edge 0.
  - `tx` is low for cycles 1-4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high.
  - `done_tx` at cycle 41; `busy` low from cycle 42.
- **Parity and order:** P=2, par 2 (odd), stop2=1, MSB_FIRST=0, push 0x03.
  - Data 1,1,0,0,0,0,0,0; parity 1; two stop bits.
  - `done_tx` at cycle 1 + 2x12 = 25.
- **Back-to-back and overflow:** DEPTH=4, P=1; push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive edges.
  - 0x11 pops at edge 1, so all five pushes are accepted.
  - A sixth push while `full` -> `ovf` pulse, word absent from the output stream.
  - The four/five frames are separated by a single DONE cycle each, in FIFO order.
- **Config latch:** change `tbit_period` 4 -> 8 and `par_mode` mid-frame.
  - The current frame completes at P=4 with no parity.
  - The next frame uses P=8 and the new parity setting.
- **Zero period:** `tbit_period`=0 behaves identically to 1 (frame of 10 cycles + DONE).
- **Reset mid-frame:** assert `rst_n` low during DATA with 2 words queued.
  - `tx`=1 and all outputs are at reset values asynchronously.
  - After release, no frame is sent until a new push.
